wfg_wb_decoder: RTL and testbench

WFG_WB_DECODER -- requirements
Module: wfg_wb_decoder

---
 rtl/wfg_wb_decoder_pkg.sv | 30 +++
 rtl/wfg_wb_decoder_if.sv | 45 ++++
 rtl/wfg_wb_decoder.sv | 183 ++++++++++++++++++
 tb/tb_wfg_wb_decoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfg_wb_decoder_pkg.sv
// -----------------------------------------------------------------------------
// wfg_wb_decoder_pkg
// Shared definitions for the Wishbone 1:N address decoder:
//   - state_t       : decoder FSM states
//   - SLAVE_BASE    : adr[19:8] match value per slave (entry 0 = timer)
//   - DEFAULT_DATA  : read data returned by the internal default slave
//   - TIMEOUT_DATA  : read data returned when a slave never acks
// -----------------------------------------------------------------------------
package wfg_wb_decoder_pkg;

  localparam int MAX_SLAVES = 8;
  localparam int SEL_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DEF  = 2'd3
  } state_t;

  // Element k is the 12-bit window selector of slave k.
  localparam logic [MAX_SLAVES-1:0][11:0] SLAVE_BASE = {
    12'hE07, 12'hE06, 12'hE05, 12'hE04,
    12'hE03, 12'hE02, 12'hE01, 12'hE00
  };

  localparam logic [31:0] DEFAULT_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] TIMEOUT_DATA = 32'hBAAD_F00D;

endpackage

// File: rtl/wfg_wb_decoder_if.sv
// -----------------------------------------------------------------------------
// wfg_wb_decoder_if
// Bundles the SoC-facing Wishbone slave port (wbs_*) and the fan-out towards
// the downstream slaves (wbm_*).
//   modport slave  : the decoder's view
//   modport master : the view of the SoC master plus the downstream slaves
// Parameter NUM_SLAVES sizes the per-slave vectors.
// -----------------------------------------------------------------------------
interface wfg_wb_decoder_if #(
  parameter int NUM_SLAVES = 4
);

  logic                     wbs_cyc_i;
  logic                     wbs_stb_i;
  logic                     wbs_we_i;
  logic [31:0]              wbs_adr_i;
  logic [31:0]              wbs_dat_i;
  logic [3:0]               wbs_sel_i;
  logic                     wbs_ack_o;
  logic [31:0]              wbs_dat_o;

  logic [NUM_SLAVES-1:0]    wbm_cyc_o;
  logic [NUM_SLAVES-1:0]    wbm_stb_o;
  logic                     wbm_we_o;
  logic [31:0]              wbm_adr_o;
  logic [31:0]              wbm_dat_o;
  logic [3:0]               wbm_sel_o;
  logic [NUM_SLAVES-1:0]    wbm_ack_i;
  logic [32*NUM_SLAVES-1:0] wbm_dat_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_dat_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_dat_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_dat_i
  );

endinterface

// File: rtl/wfg_wb_decoder.sv
// -----------------------------------------------------------------------------
// wfg_wb_decoder
// Wishbone 1:N decoder. A request is routed to the slave whose SLAVE_BASE
// equals wbs_adr_i[19:8]; unmatched addresses are answered by an internal
// default slave (DEADBEEF on reads, writes dropped, sticky error raised).
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : wfg_wb_decoder_if.slave (wbs_* from SoC, wbm_* to slaves)
//   err_o      : sticky bus-error flag
//   clr_err_i  : synchronous clear of err_o (a simultaneous set wins)
//
// Optional build macro
//   WFG_WB_TIMEOUT_EN : adds a watchdog that completes a WAIT with
//                       TIMEOUT_DATA and raises err_o after TIMEOUT_CYCLES.
// -----------------------------------------------------------------------------
module wfg_wb_decoder
  import wfg_wb_decoder_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  wfg_wb_decoder_if.slave bus,
  output logic            err_o,
  input  logic            clr_err_i
);

  state_t                r_state;
  state_t                w_state_next;
  logic [SEL_W-1:0]      r_sel_q;
  logic [31:0]           r_dat;
  logic                  r_err;

  logic                  w_req;
  logic [NUM_SLAVES-1:0] w_hit;
  logic                  w_dec_hit;
  logic [SEL_W-1:0]      w_dec_idx;
  logic                  w_sel_ack;
  logic [31:0]           w_sel_dat;
  logic                  w_timeout;
  logic [NUM_SLAVES-1:0] w_cyc;
  logic                  w_ack;
  logic                  w_load_dat;
  logic [31:0]           w_dat_next;
  logic                  w_err_set;

  assign w_req = bus.wbs_cyc_i & bus.wbs_stb_i;

  // Shared fan-out: slaves only act on these while their own strobe is high.
  assign bus.wbm_we_o  = bus.wbs_we_i;
  assign bus.wbm_adr_o = bus.wbs_adr_i;
  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign bus.wbm_sel_o = bus.wbs_sel_i;

  // Address decode: one comparator per slave window.
  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
    assign w_hit[gi] = (bus.wbs_adr_i[19:8] == SLAVE_BASE[gi]);
  end

  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_dec_hit = 1'b1;
        w_dec_idx = SEL_W'(k);
      end
    end
  end

  // Only the slave latched in r_sel_q may complete the transfer.
  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_sel_q == SEL_W'(k)) begin
        w_sel_ack = bus.wbm_ack_i[k];
        w_sel_dat = bus.wbm_dat_i[32*k +: 32];
      end
    end
  end

`ifdef WFG_WB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state != WAIT) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // Fires on the edge that closes the TIMEOUT_CYCLES-th WAIT cycle.
  assign w_timeout = (r_state == WAIT) && (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_timeout    = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state. A dropped cycle outranks a same-cycle ack.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_req) w_state_next = w_dec_hit ? WAIT : DEF;
      WAIT: begin
        if (!bus.wbs_cyc_i)             w_state_next = IDLE;
        else if (w_sel_ack || w_timeout) w_state_next = RESP;
      end
      RESP:    w_state_next = IDLE;
      DEF:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_cyc = '0;
    w_ack = 1'b0;
    unique case (r_state)
      WAIT:      w_cyc = NUM_SLAVES'(1) << r_sel_q;
      RESP, DEF: w_ack = 1'b1;
      default:   ;
    endcase
  end

  assign bus.wbm_cyc_o = w_cyc;
  assign bus.wbm_stb_o = w_cyc;
  assign bus.wbs_ack_o = w_ack;

  // Response data and error events, all taken on the edge entering RESP/DEF.
  always_comb begin
    w_load_dat = 1'b0;
    w_dat_next = r_dat;
    w_err_set  = 1'b0;
    if (r_state == IDLE && w_req && !w_dec_hit) begin
      w_err_set  = 1'b1;
      w_load_dat = !bus.wbs_we_i;
      w_dat_next = DEFAULT_DATA;
    end else if (r_state == WAIT && bus.wbs_cyc_i) begin
      if (w_sel_ack) begin
        w_load_dat = 1'b1;
        w_dat_next = w_sel_dat;
      end else if (w_timeout) begin
        w_load_dat = 1'b1;
        w_dat_next = TIMEOUT_DATA;
        w_err_set  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_q <= '0;
      r_dat   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_req) r_sel_q <= w_dec_idx;
      if (w_load_dat)               r_dat   <= w_dat_next;
      r_err <= w_err_set | (r_err & ~clr_err_i);
    end
  end

  assign bus.wbs_dat_o = r_dat;
  assign err_o         = r_err;

endmodule

// File: tb/tb_wfg_wb_decoder.sv
// -----------------------------------------------------------------------------
// tb_wfg_wb_decoder
// Self-checking bench for wfg_wb_decoder. A transaction-level model tracks
// the expected latency, read data and sticky error for every transfer.
// Build with +define+WFG_WB_TIMEOUT_EN to exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_wfg_wb_decoder;

  localparam int NS  = 4;
  localparam int TMO = 8;

  logic clk;
  logic rst_n;
  logic clr_err_i;
  logic err_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_dat;
  logic        exp_err;
  logic [11:0] base_tab [NS] = '{12'hE00, 12'hE01, 12'hE02, 12'hE03};

  wfg_wb_decoder_if #(.NUM_SLAVES(NS)) bus ();

  wfg_wb_decoder #(
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_o     (err_o),
    .clr_err_i (clr_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int map_index(input logic [31:0] adr);
    for (int k = 0; k < NS; k++) if (adr[19:8] == base_tab[k]) return k;
    return -1;
  endfunction

  // One Wishbone transfer from the master side, with a behavioural slave
  // that acks after dly+1 strobe cycles. Starts and ends just after a posedge.
  task automatic xfer(input logic [31:0] adr, input logic we, input int dly,
                      input logic [31:0] sdat, input bit noise, input bit clr_e0,
                      output int lat, output logic [31:0] dat, output logic err,
                      output logic [NS-1:0] stb_seen, output logic [NS-1:0] cyc_seen,
                      output int stb_cycles);
    int sel_k;
    int oth;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_adr_i = adr;
    bus.wbs_we_i  = we;
    bus.wbs_dat_i = $urandom;
    bus.wbs_sel_i = 4'($urandom);
    clr_err_i     = clr_e0;
    @(posedge clk);
    lat = 0; dat = '0; err = 1'b0; stb_seen = '0; cyc_seen = '0; stb_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      clr_err_i     = 1'b0;
      bus.wbm_ack_i = '0;
      if (bus.wbs_ack_o) begin
        lat = i; dat = bus.wbs_dat_o; err = err_o;
        break;
      end
      stb_seen |= bus.wbm_stb_o;
      cyc_seen |= bus.wbm_cyc_o;
      for (int k = 0; k < NS; k++) bus.wbm_dat_i[32*k +: 32] = $urandom;
      if (bus.wbm_stb_o != '0) begin
        stb_cycles++;
        sel_k = 0;
        for (int k = 0; k < NS; k++) if (bus.wbm_stb_o[k]) sel_k = k;
        if (stb_cycles == dly + 1) begin
          bus.wbm_ack_i[sel_k]            = 1'b1;
          bus.wbm_dat_i[32*sel_k +: 32]   = sdat;
        end
        if (noise) begin
          oth = (sel_k + 1 + int'($urandom_range(0, NS - 2))) % NS;
          bus.wbm_ack_i[oth] = 1'b1;
        end
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbm_ack_i = '0;
    clr_err_i     = 1'b0;
    @(posedge clk); #1;
    $display("xfer adr=%h we=%0d dly=%0d lat=%0d dat=%h err=%0d stb=%b",
             adr, we, dly, lat, dat, err, stb_seen);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_err_i = 1'b0;
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.wbs_sel_i = '0;
    bus.wbm_ack_i = '0; bus.wbm_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b expected 0", bus.wbs_ack_o); end
    total++; if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat: got %h expected 0", bus.wbs_dat_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", err_o); end
    total++; if (bus.wbm_cyc_o !== '0 || bus.wbm_stb_o !== '0) begin
      bad++; $display("FAIL reset_cyc_stb: got %b/%b expected 0/0", bus.wbm_cyc_o, bus.wbm_stb_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_dat = '0; exp_err = 1'b0;
  endtask

  task automatic test_fanout();
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        w;
    for (int n = 0; n < 4; n++) begin
      a = $urandom; d = $urandom; s = 4'($urandom); w = 1'($urandom);
      bus.wbs_adr_i = a; bus.wbs_dat_i = d; bus.wbs_sel_i = s; bus.wbs_we_i = w;
      #1;
      total++;
      if (bus.wbm_adr_o !== a || bus.wbm_dat_o !== d || bus.wbm_sel_o !== s || bus.wbm_we_o !== w) begin
        bad++;
        $display("FAIL fanout: got %h/%h/%h/%b expected %h/%h/%h/%b",
                 bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o, bus.wbm_we_o, a, d, s, w);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mapped_read();
    int lat, cyc_n; logic [31:0] dat; logic err; logic [NS-1:0] stb, cyc;
    xfer(32'h000E_0004, 1'b0, 0, 32'h1234_5678, 1'b0, 1'b0, lat, dat, err, stb, cyc, cyc_n);
    exp_dat = 32'h1234_5678;
    total++; if (lat !== 2) begin bad++; $display("FAIL map_lat: got %0d expected 2", lat); end
    total++; if (dat !== exp_dat) begin bad++; $display("FAIL map_dat: got %h expected %h", dat, exp_dat); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL map_err: got %b expected 0", err); end
    total++; if (stb !== 4'b0001 || cyc !== 4'b0001) begin
      bad++; $display("FAIL map_stb: got %b/%b expected 0001/0001", stb, cyc);
    end
  endtask

  task automatic test_unmapped();
    int lat, cyc_n; logic [31:0] dat; logic err; logic [NS-1:0] stb, cyc;
    xfer(32'h0008_F000, 1'b1, 0, 32'h0, 1'b0, 1'b0, lat, dat, err, stb, cyc, cyc_n);
    exp_err = 1'b1;
    total++; if (lat !== 1) begin bad++; $display("FAIL unmap_wr_lat: got %0d expected 1", lat); end
    total++; if (stb !== '0) begin bad++; $display("FAIL unmap_wr_stb: got %b expected 0000", stb); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL unmap_wr_err: got %b expected 1", err); end
    total++; if (dat !== exp_dat) begin bad++; $display("FAIL unmap_wr_dat: got %h expected %h", dat, exp_dat); end
    clr_err_i = 1'b1;
    @(posedge clk); #1;
    clr_err_i = 1'b0;
    exp_err = 1'b0;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_clear: got %b expected 0", err_o); end
    xfer(32'h0008_F000, 1'b0, 0, 32'h0, 1'b0, 1'b0, lat, dat, err, stb, cyc, cyc_n);
    exp_dat = 32'hDEAD_BEEF; exp_err = 1'b1;
    total++; if (dat !== exp_dat) begin bad++; $display("FAIL unmap_rd_dat: got %h expected %h", dat, exp_dat); end
  endtask

  task automatic test_set_wins_clear();
    int lat, cyc_n; logic [31:0] dat; logic err; logic [NS-1:0] stb, cyc;
    // err is already 1 here; clear coinciding with a new error must keep it 1.
    xfer(32'h0003_7700, 1'b0, 0, 32'h0, 1'b0, 1'b1, lat, dat, err, stb, cyc, cyc_n);
    exp_err = 1'b1;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL set_wins: got %b expected 1", err); end
    xfer(32'h000E_0204, 1'b1, 1, 32'hA5A5_0001, 1'b0, 1'b1, lat, dat, err, stb, cyc, cyc_n);
    exp_err = 1'b0; exp_dat = 32'hA5A5_0001;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_mapped: got %b expected 0", err); end
    total++; if (lat !== 3) begin bad++; $display("FAIL dly1_lat: got %0d expected 3", lat); end
  endtask

  task automatic test_unselected_ack();
    int lat, cyc_n; logic [31:0] dat; logic err; logic [NS-1:0] stb, cyc;
    xfer(32'h000E_0010, 1'b0, 2, 32'h0BAD_CAFE, 1'b1, 1'b0, lat, dat, err, stb, cyc, cyc_n);
    exp_dat = 32'h0BAD_CAFE;
    total++; if (lat !== 4) begin bad++; $display("FAIL unsel_lat: got %0d expected 4", lat); end
    total++; if (dat !== exp_dat) begin bad++; $display("FAIL unsel_dat: got %h expected %h", dat, exp_dat); end
  endtask

  task automatic test_cyc_drop();
    int lat, cyc_n, late_acks; logic [31:0] dat; logic err; logic [NS-1:0] stb, cyc;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 32'h000E_0100;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    // Drop the cycle while slave 1 acks: the ack must be discarded.
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    bus.wbm_ack_i[1] = 1'b1; bus.wbm_dat_i[63:32] = 32'hFFFF_0000;
    @(posedge clk); #1;
    bus.wbm_ack_i = '0;
    late_acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o || bus.wbm_stb_o != '0) late_acks++;
    end
    @(posedge clk); #1;
    $display("xfer adr=000e0100 aborted late_acks=%0d", late_acks);
    total++; if (late_acks !== 0) begin bad++; $display("FAIL abort_ack: got %0d expected 0", late_acks); end
    total++; if (bus.wbs_dat_o !== exp_dat) begin bad++; $display("FAIL abort_dat: got %h expected %h", bus.wbs_dat_o, exp_dat); end
    xfer(32'h000E_0200, 1'b0, 0, 32'h2222_3333, 1'b0, 1'b0, lat, dat, err, stb, cyc, cyc_n);
    exp_dat = 32'h2222_3333;
    total++; if (lat !== 2 || dat !== exp_dat) begin
      bad++; $display("FAIL after_abort: got lat %0d dat %h expected lat 2 dat %h", lat, dat, exp_dat);
    end
  endtask

  task automatic test_no_ack();
    int lat, cyc_n; logic [31:0] dat; logic err; logic [NS-1:0] stb, cyc;
    xfer(32'h000E_0300, 1'b0, 1000, 32'h0, 1'b0, 1'b0, lat, dat, err, stb, cyc, cyc_n);
`ifdef WFG_WB_TIMEOUT_EN
    exp_dat = 32'hBAAD_F00D; exp_err = 1'b1;
    total++; if (lat !== TMO + 1) begin bad++; $display("FAIL tmo_lat: got %0d expected %0d", lat, TMO + 1); end
    total++; if (cyc_n !== TMO) begin bad++; $display("FAIL tmo_cycles: got %0d expected %0d", cyc_n, TMO); end
    total++; if (dat !== exp_dat) begin bad++; $display("FAIL tmo_dat: got %h expected %h", dat, exp_dat); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b expected 1", err); end
`else
    total++; if (lat !== 0) begin bad++; $display("FAIL noack_lat: got %0d expected none", lat); end
    total++; if (cyc_n !== 40) begin bad++; $display("FAIL noack_cycles: got %0d expected 40", cyc_n); end
    total++; if (bus.wbs_dat_o !== exp_dat || err_o !== exp_err) begin
      bad++; $display("FAIL noack_hold: got %h/%b expected %h/%b", bus.wbs_dat_o, err_o, exp_dat, exp_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int lat, cyc_n, late_acks; logic [31:0] dat; logic err; logic [NS-1:0] stb, cyc;
    xfer(32'h0000_0000, 1'b0, 0, 32'h0, 1'b0, 1'b0, lat, dat, err, stb, cyc, cyc_n);
    total++; if (dat !== 32'hDEAD_BEEF || err !== 1'b1) begin
      bad++; $display("FAIL pre_rst: got %h/%b expected deadbeef/1", dat, err);
    end
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = 32'h000E_0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.wbm_stb_o !== '0 || bus.wbm_cyc_o !== '0 || bus.wbs_ack_o !== 1'b0 ||
        bus.wbs_dat_o !== 32'h0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: got stb %b cyc %b ack %b dat %h err %b expected all 0",
               bus.wbm_stb_o, bus.wbm_cyc_o, bus.wbs_ack_o, bus.wbs_dat_o, err_o);
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_dat = '0; exp_err = 1'b0;
    late_acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o || bus.wbm_stb_o != '0) late_acks++;
    end
    @(posedge clk); #1;
    $display("xfer adr=000e0000 reset-dropped late_acks=%0d", late_acks);
    total++; if (late_acks !== 0) begin bad++; $display("FAIL rst_drop: got %0d expected 0", late_acks); end
  endtask

  task automatic test_random();
    int lat, cyc_n, k, dly, exp_lat, exp_n;
    logic [31:0] adr, sdat, dat;
    logic [11:0] blk;
    logic we, err, clr;
    bit noise;
    logic [NS-1:0] stb, cyc, exp_stb;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        k = int'($urandom_range(0, NS - 1));
        blk = base_tab[k];
      end else begin
        // Half the misses sit in the package windows beyond NUM_SLAVES.
        if ($urandom_range(0, 1) == 1) blk = 12'hE04 + 12'($urandom_range(0, 3));
        else blk = 12'($urandom);
      end
      adr   = {12'($urandom), blk, 8'($urandom)};
      k     = map_index(adr);
      we    = 1'($urandom);
      dly   = int'($urandom_range(0, 3));
      sdat  = $urandom;
      noise = 1'($urandom);
      clr   = ($urandom_range(0, 4) == 0);
      xfer(adr, we, dly, sdat, noise, clr, lat, dat, err, stb, cyc, cyc_n);
      if (clr) exp_err = 1'b0;
      if (k >= 0) begin
        exp_lat = 2 + dly; exp_dat = sdat; exp_stb = NS'(1) << k; exp_n = dly + 1;
      end else begin
        exp_lat = 1; exp_err = 1'b1; exp_stb = '0; exp_n = 0;
        if (!we) exp_dat = 32'hDEAD_BEEF;
      end
      total++;
      if (lat !== exp_lat || dat !== exp_dat || err !== exp_err || stb !== exp_stb ||
          cyc !== exp_stb || cyc_n !== exp_n) begin
        bad++;
        $display("FAIL rand_%0d: got lat %0d dat %h err %b stb %b cyc %b n %0d expected lat %0d dat %h err %b stb %b n %0d",
                 n, lat, dat, err, stb, cyc, cyc_n, exp_lat, exp_dat, exp_err, exp_stb, exp_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fanout();
    test_mapped_read();
    test_unmapped();
    test_set_wins_clear();
    test_unselected_ack();
    test_cyc_drop();
    test_no_ack();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
